// File: rtl/ram_writer.sv
// ram_writer: valid/ready stream sink writing sequential RAM addresses, with a registered read port
module ram_writer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4096,
   parameter int ADDRW = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [ADDRW-1:0] base_addr,
   input  logic [ADDRW:0]   length,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [ADDRW:0]   wr_count,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [ADDRW-1:0] base;
   logic [ADDRW:0]   len;
   logic             beat;
   logic [ADDRW-1:0] wr_addr;
   assign beat    = in_valid && in_ready;
   assign wr_addr = base + wr_count[ADDRW-1:0];
   // state register; reset aborts any transfer without a done pulse
   always_ff @(posedge clk)
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   // next state: zero-length transfers skip straight to the done pulse
   always_comb begin
      state_nx = state == S_IDLE  ? (start ? (length == '0 ? S_DONE : S_WRITE) : S_IDLE)
               : state == S_WRITE ? ((beat && wr_count + 1'b1 == len) ? S_DONE : S_WRITE)
               : S_IDLE;
   end
   // outputs decoded from the registered state only
   always_comb begin
      in_ready = state == S_WRITE;
      busy     = state == S_WRITE;
      done     = state == S_DONE;
   end
   // transfer parameters latch on an accepted start; count advances per beat
   always_ff @(posedge clk)
      if (!rst_n) begin
         base     <= '0;
         len      <= '0;
         wr_count <= '0;
      end else if (state == S_IDLE && start) begin
         base     <= base_addr;
         len      <= length;
         wr_count <= '0;
      end else if (beat) begin
         wr_count <= wr_count + 1'b1;
      end
   // memory write; contents survive reset, but no write lands on a reset edge
   always_ff @(posedge clk)
      if (rst_n && beat) mem[wr_addr] <= in_data;
   // read-first registered read port
   always_ff @(posedge clk)
      if (!rst_n) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed stimulus with scoreboard queues for readback and done pulses
module tb_ram_writer;
   logic        clk = 0;
   logic        rst_n, start, in_valid, in_ready, busy, done;
   logic [11:0] base_addr, rd_addr;
   logic [12:0] length, wr_count;
   logic [31:0] in_data, rd_data;
   logic        rd_req = 0, rd_live = 0;
   logic [31:0] rd_q[$];
   logic [12:0] done_q[$];
   int          checks = 0, errors = 0;

   ram_writer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done),
      .wr_count(wr_count), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_live <= rd_req;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: compares every registered read and every done pulse against the queues
   always @(negedge clk) begin
      if (rd_live) begin
         if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
         else check("rd_data", rd_data, rd_q.pop_front());
      end
      if (done) begin
         if (done_q.size() == 0) check("done_unexpected", 1, 0);
         else check("done_wr_count", wr_count, done_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [11:0] b, input logic [12:0] l);
      base_addr = b;
      length    = l;
      start     = 1;
      tick();
      start     = 0;
   endtask

   task automatic beat(input logic [31:0] d);
      check("in_ready_before_beat", in_ready, 1);
      in_valid = 1;
      in_data  = d;
      tick();
      in_valid = 0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp);
      rd_addr = a;
      rd_req  = 1;
      rd_q.push_back(exp);
      tick();
      rd_req  = 0;
   endtask

   initial begin
      rst_n = 0; start = 0; in_valid = 0; in_data = 0;
      base_addr = 0; length = 0; rd_addr = 0;
      tick(); tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1;
      tick();

      // basic transfer
      do_start(12'h010, 4);
      check("basic_busy", busy, 1);
      beat(32'hA0); beat(32'hA1); beat(32'hA2);
      done_q.push_back(4);
      beat(32'hA3);
      check("basic_done", done, 1);
      check("basic_busy_off", busy, 0);
      check("basic_ready_off", in_ready, 0);
      tick();
      check("basic_done_once", done, 0);
      check("basic_count_hold", wr_count, 4);
      rd(12'h010, 32'hA0); rd(12'h011, 32'hA1); rd(12'h012, 32'hA2); rd(12'h013, 32'hA3);

      // backpressure gaps
      do_start(12'h040, 3);
      beat(32'hB0);
      check("bp_count1", wr_count, 1);
      tick();
      check("bp_stall1", wr_count, 1);
      beat(32'hB1);
      check("bp_count2", wr_count, 2);
      tick();
      check("bp_stall2", wr_count, 2);
      check("bp_no_done", done, 0);
      done_q.push_back(3);
      beat(32'hB2);
      check("bp_done", done, 1);
      tick();
      rd(12'h040, 32'hB0); rd(12'h041, 32'hB1); rd(12'h042, 32'hB2);

      // wrap-around
      do_start(12'hFFE, 4);
      beat(32'hD0); beat(32'hD1); beat(32'hD2);
      done_q.push_back(4);
      beat(32'hD3);
      tick();
      rd(12'hFFE, 32'hD0); rd(12'hFFF, 32'hD1); rd(12'h000, 32'hD2); rd(12'h001, 32'hD3);

      // zero length with a stray valid word
      in_valid = 1;
      in_data  = 32'hDEAD;
      done_q.push_back(0);
      do_start(12'h000, 0);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_ready", in_ready, 0);
      tick();
      in_valid = 0;
      rd(12'h000, 32'hD2);

      // start during WRITE is ignored
      do_start(12'h100, 2);
      beat(32'hE0);
      base_addr = 12'h200;
      length    = 5;
      start     = 1;
      tick();
      start     = 0;
      check("ign_count", wr_count, 1);
      done_q.push_back(2);
      beat(32'hE1);
      check("ign_done", done, 1);
      tick();
      rd(12'h100, 32'hE0); rd(12'h101, 32'hE1);

      // read/write collision is read-first
      do_start(12'h020, 1);
      done_q.push_back(1);
      beat(32'h0000_00AA);
      tick();
      do_start(12'h020, 1);
      rd_addr  = 12'h020;
      rd_req   = 1;
      rd_q.push_back(32'h0000_00AA);
      done_q.push_back(1);
      beat(32'h0000_00BB);
      rd_req   = 0;
      tick();
      rd(12'h020, 32'h0000_00BB);

      // reset mid-transfer: third beat lands on the reset edge and must not write
      do_start(12'h00F, 5);
      beat(32'hF0); beat(32'hF1);
      in_valid = 1;
      in_data  = 32'hF2;
      rst_n    = 0;
      tick();
      in_valid = 0;
      check("abort_ready", in_ready, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_count", wr_count, 0);
      rst_n = 1;
      tick();
      check("abort_no_done", done, 0);
      rd(12'h00F, 32'hF0); rd(12'h010, 32'hF1); rd(12'h011, 32'hA1);

      tick(); tick();
      check("rd_queue_drained", rd_q.size(), 0);
      check("done_queue_drained", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
